// File: rtl/word_pack_2048_pkg.sv
// rtl/word_pack_2048_pkg.sv - shared constants and slot helper for the 2048-bit word packer
package word_pack_2048_pkg;

    localparam int IN_W  = 64;
    localparam int OUT_W = 2048;
    localparam int RATIO = OUT_W / IN_W;
    localparam int CNT_W = $clog2(RATIO);

    // Bit offset of slot i inside a packed word (slot 0 is the LSB end).
    function automatic int slot_base(input int i);
        return i * IN_W;
    endfunction

endpackage

// File: rtl/word_pack_2048.sv
// rtl/word_pack_2048.sv - width-up packer, IN_W beats to OUT_W words with end-of-frame flush
//
// Ports:
//   clock, reset                 single clock, synchronous active-high reset
//   io_enq_bits/last/valid/ready narrow input beats, last flushes a zero-padded word
//   io_deq_bits/last/valid/ready packed output words, driven straight from registers
module word_pack_2048
    import word_pack_2048_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic [IN_W-1:0]  io_enq_bits,
    input  logic             io_enq_last,
    input  logic             io_enq_valid,
    output logic             io_enq_ready,
    output logic [OUT_W-1:0] io_deq_bits,
    output logic             io_deq_last,
    output logic             io_deq_valid,
    input  logic             io_deq_ready
);

    logic [OUT_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             acc_full_q, acc_full_d;
    logic             acc_last_q, acc_last_d;
    logic [OUT_W-1:0] out_q, out_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;

    logic out_free;
    logic move;
    logic enq_fire;
    logic deq_fire;

    // Assembly stage plus output register act as a two-entry skid: a full
    // assembly word may wait behind an unaccepted output word, and the
    // packer only stalls when both are occupied.
    assign out_free     = !out_valid_q || io_deq_ready;
    assign io_enq_ready = !acc_full_q || out_free;
    assign move         = acc_full_q && out_free;
    assign enq_fire     = io_enq_valid && io_enq_ready;
    assign deq_fire     = out_valid_q && io_deq_ready;

    assign io_deq_bits  = out_q;
    assign io_deq_last  = out_last_q;
    assign io_deq_valid = out_valid_q;

    always_comb begin
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        acc_full_d  = acc_full_q;
        acc_last_d  = acc_last_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;

        if (move) begin
            out_d       = acc_q;
            out_valid_d = 1'b1;
            out_last_d  = acc_last_q;
            acc_full_d  = 1'b0;
            // Clearing here, before the enq write below, is what zero-pads
            // the next word while still letting a same-cycle beat land in slot 0.
            acc_d       = '0;
        end else if (deq_fire) begin
            out_valid_d = 1'b0;
        end

        if (enq_fire) begin
            acc_d[slot_base(int'(cnt_q)) +: IN_W] = io_enq_bits;
            if (cnt_q == CNT_W'(RATIO - 1) || io_enq_last) begin
                acc_full_d = 1'b1;
                acc_last_d = io_enq_last;
                cnt_d      = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            acc_full_q  <= 1'b0;
            acc_last_q  <= 1'b0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            acc_full_q  <= acc_full_d;
            acc_last_q  <= acc_last_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

endmodule

// File: tb/tb_word_pack_2048.sv
// tb/tb_word_pack_2048.sv - self-checking bench for word_pack_2048
module tb_word_pack_2048;

    logic          clock;
    logic          reset;
    logic [63:0]   io_enq_bits;
    logic          io_enq_last;
    logic          io_enq_valid;
    logic          io_enq_ready;
    logic [2047:0] io_deq_bits;
    logic          io_deq_last;
    logic          io_deq_valid;
    logic          io_deq_ready;

    word_pack_2048 dut (
        .clock        (clock),
        .reset        (reset),
        .io_enq_bits  (io_enq_bits),
        .io_enq_last  (io_enq_last),
        .io_enq_valid (io_enq_valid),
        .io_enq_ready (io_enq_ready),
        .io_deq_bits  (io_deq_bits),
        .io_deq_last  (io_deq_last),
        .io_deq_valid (io_deq_valid),
        .io_deq_ready (io_deq_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [2047:0] bits;
        logic          last;
    } word_t;

    typedef struct {
        int          nbeats;
        logic [63:0] base;
        bit          last_end;
        int          exp_words;
        bit          exp_last;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    word_t         exp_q[$];
    int            deq_cyc[$];
    logic [2047:0] m_acc = '0;
    int            m_cnt = 0;
    int            words_out = 0;
    logic          last_word_last = 1'b0;
    logic          hold_valid = 1'b0;
    logic [2047:0] held_bits = '0;
    logic          held_last = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk_word(input string name, input logic [2047:0] act, input logic [2047:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            for (int s = 0; s < 32; s++) begin
                if (act[s*64 +: 64] !== exp[s*64 +: 64]) begin
                    $display("FAIL %s slot %0d actual=%0h required=%0h", name, s,
                             act[s*64 +: 64], exp[s*64 +: 64]);
                    break;
                end
            end
        end
    endtask

    // Reference model: words are formed from accepted beats (32 per word, or
    // fewer when a beat carries last), and at most two completed words can be
    // held, so the packer refuses beats only with two held and deq blocked.
    always @(negedge clock) begin
        word_t w;
        if (reset) begin
            m_acc = '0;
            m_cnt = 0;
            exp_q.delete();
            hold_valid = 1'b0;
        end else begin
            chk("enq_ready", 64'(io_enq_ready), 64'(!(exp_q.size() == 2 && !io_deq_ready)));
            if (hold_valid) begin
                chk("deq_valid_held", 64'(io_deq_valid), 64'd1);
                chk_word("deq_bits_held", io_deq_bits, held_bits);
                chk("deq_last_held", 64'(io_deq_last), 64'(held_last));
            end
            if (io_deq_valid && io_deq_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", 64'd1, 64'd0);
                end else begin
                    w = exp_q.pop_front();
                    chk_word("deq_bits", io_deq_bits, w.bits);
                    chk("deq_last", 64'(io_deq_last), 64'(w.last));
                end
                words_out++;
                last_word_last = io_deq_last;
                deq_cyc.push_back(cyc);
            end
            hold_valid = io_deq_valid && !io_deq_ready;
            held_bits  = io_deq_bits;
            held_last  = io_deq_last;
            if (io_enq_valid && io_enq_ready) begin
                m_acc[m_cnt*64 +: 64] = io_enq_bits;
                m_cnt++;
                if (m_cnt == 32 || io_enq_last) begin
                    w.bits = m_acc;
                    w.last = io_enq_last;
                    exp_q.push_back(w);
                    m_acc = '0;
                    m_cnt = 0;
                end
            end
        end
    end

    task automatic stream(input int n, input logic [63:0] base, input bit last_end, output int stalls);
        int  k;
        bit  f;
        k = 0;
        stalls = 0;
        io_enq_valid = 1'b1;
        io_enq_bits  = base;
        io_enq_last  = last_end && n == 1;
        for (int c = 0; c < n + 2000 && k < n; c++) begin
            @(negedge clock);
            f = io_enq_ready;
            if (!f) stalls++;
            @(posedge clock);
            #1;
            if (f) begin
                k++;
                io_enq_bits = base + 64'(k);
                io_enq_last = last_end && k == n - 1;
            end
        end
        io_enq_valid = 1'b0;
        io_enq_last  = 1'b0;
        chk("stream_done", 64'(k), 64'(n));
    endtask

    task automatic drain();
        int c;
        io_deq_ready = 1'b1;
        c = 0;
        while ((exp_q.size() != 0 || io_deq_valid) && c < 300) begin
            @(posedge clock);
            #1;
            c++;
        end
        chk("drain_timeout", 64'(c < 300), 64'd1);
    endtask

    vec_t vecs[7];

    initial begin
        int st;
        int w0;
        int n;
        bit f;

        vecs[0] = '{nbeats: 32, base: 64'h100, last_end: 0, exp_words: 1, exp_last: 0};
        vecs[1] = '{nbeats: 3,  base: 64'hA,   last_end: 1, exp_words: 1, exp_last: 1};
        vecs[2] = '{nbeats: 1,  base: 64'h77,  last_end: 1, exp_words: 1, exp_last: 1};
        vecs[3] = '{nbeats: 32, base: 64'h200, last_end: 1, exp_words: 1, exp_last: 1};
        vecs[4] = '{nbeats: 2,  base: 64'h300, last_end: 1, exp_words: 1, exp_last: 1};
        vecs[5] = '{nbeats: 64, base: 64'h400, last_end: 0, exp_words: 2, exp_last: 0};
        vecs[6] = '{nbeats: 40, base: 64'h600, last_end: 1, exp_words: 2, exp_last: 1};

        reset = 1'b1;
        io_enq_bits = '0;
        io_enq_last = 1'b0;
        io_enq_valid = 1'b0;
        io_deq_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        chk("rst_deq_valid", 64'(io_deq_valid), 64'd0);
        chk("rst_deq_last", 64'(io_deq_last), 64'd0);
        chk("rst_enq_ready", 64'(io_enq_ready), 64'd1);
        chk_word("rst_deq_bits", io_deq_bits, '0);
        @(posedge clock);
        #1;

        // Table-driven frames; data is checked word by word by the model.
        foreach (vecs[i]) begin
            w0 = words_out;
            stream(vecs[i].nbeats, vecs[i].base, vecs[i].last_end, st);
            drain();
            chk("vec_words", 64'(words_out - w0), 64'(vecs[i].exp_words));
            chk("vec_last", 64'(last_word_last), 64'(vecs[i].exp_last));
            chk("vec_stalls", 64'(st), 64'd0);
        end

        // Latency: final beat accepted in cycle t gives deq valid in cycle t+2.
        stream(32, 64'h100, 0, st);
        @(negedge clock);
        chk("lat_t1_valid", 64'(io_deq_valid), 64'd0);
        @(negedge clock);
        chk("lat_t2_valid", 64'(io_deq_valid), 64'd1);
        drain();

        // Backpressure: exactly two words buffered, then enq resumes immediately.
        @(posedge clock);
        #1;
        io_deq_ready = 1'b0;
        w0 = words_out;
        n = 0;
        io_enq_valid = 1'b1;
        io_enq_bits = 64'h800;
        repeat (80) begin
            @(negedge clock);
            f = io_enq_ready;
            @(posedge clock);
            #1;
            if (f) begin
                n++;
                io_enq_bits = 64'h800 + 64'(n);
            end
        end
        chk("full_beats", 64'(n), 64'd64);
        chk("full_ready", 64'(io_enq_ready), 64'd0);
        io_deq_ready = 1'b1;
        @(negedge clock);
        chk("full_resume", 64'(io_enq_ready), 64'd1);
        @(posedge clock);
        #1;
        io_enq_valid = 1'b0;
        stream(1, 64'h8FF, 1, st);
        drain();
        chk("full_words", 64'(words_out - w0), 64'd3);

        // Sustained 320 beats: no stalls, one word per 32 cycles.
        w0 = words_out;
        deq_cyc.delete();
        stream(320, 64'h1000, 0, st);
        drain();
        chk("sus_stalls", 64'(st), 64'd0);
        chk("sus_words", 64'(words_out - w0), 64'd10);
        for (int i = 1; i < deq_cyc.size(); i++)
            chk("sus_gap", 64'(deq_cyc[i] - deq_cyc[i-1]), 64'd32);

        // Reset mid-word discards the partial word.
        stream(17, 64'hDEAD0000, 0, st);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        chk("midrst_deq_valid", 64'(io_deq_valid), 64'd0);
        chk("midrst_enq_ready", 64'(io_enq_ready), 64'd1);
        w0 = words_out;
        stream(32, 64'h5000, 0, st);
        drain();
        chk("midrst_words", 64'(words_out - w0), 64'd1);

        // Randomised traffic with random backpressure and frame ends.
        for (int c = 0; c < 4000; c++) begin
            @(posedge clock);
            #1;
            io_enq_valid = ($urandom % 4) != 0;
            io_enq_bits  = {$urandom, $urandom};
            io_enq_last  = ($urandom % 16) == 0;
            io_deq_ready = ($urandom % 3) != 0;
        end
        @(posedge clock);
        #1;
        io_enq_valid = 1'b0;
        io_enq_last = 1'b0;
        stream(1, 64'hF00D, 1, st);
        drain();
        chk("rand_model_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
